// File: rtl/logic_axi4_lite_pkg.sv
// Shared AXI4-Lite types.
//   access_t   : AxPROT encoding {instruction, non-secure, privileged}
//   response_t : xRESP encoding
package logic_axi4_lite_pkg;

  typedef logic [2:0] access_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } response_t;

endpackage

// File: rtl/logic_axi4_lite_write_arbiter.sv
// Round-robin arbiter sharing one downstream AXI4-Lite write path (AW, W, B)
// among MASTERS upstream requesters. A grant is held for one complete write,
// from AW/W acceptance through delivery of the write response.
//
// Ports:
//   aclk, areset_n              clock, asynchronous active-low reset
//   slave_aw*/slave_w*/slave_b* per-requester upstream channels
//   master_aw*/master_w*/master_b* single downstream channel set
module logic_axi4_lite_write_arbiter #(
  parameter int unsigned MASTERS       = 2,
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                                        aclk,
  input  logic                                        areset_n,
  input  logic [MASTERS-1:0]                          slave_awvalid,
  input  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0]       slave_awaddr,
  input  logic_axi4_lite_pkg::access_t [MASTERS-1:0]  slave_awprot,
  output logic [MASTERS-1:0]                          slave_awready,
  input  logic [MASTERS-1:0]                          slave_wvalid,
  input  logic [MASTERS-1:0][DATA_BYTES-1:0][7:0]     slave_wdata,
  input  logic [MASTERS-1:0][DATA_BYTES-1:0]          slave_wstrb,
  output logic [MASTERS-1:0]                          slave_wready,
  input  logic [MASTERS-1:0]                          slave_bready,
  output logic [MASTERS-1:0]                          slave_bvalid,
  output logic_axi4_lite_pkg::response_t [MASTERS-1:0] slave_bresp,
  output logic                                        master_awvalid,
  output logic [ADDRESS_WIDTH-1:0]                    master_awaddr,
  output logic_axi4_lite_pkg::access_t                master_awprot,
  input  logic                                        master_awready,
  output logic                                        master_wvalid,
  output logic [DATA_BYTES*8-1:0]                     master_wdata,
  output logic [DATA_BYTES-1:0]                       master_wstrb,
  input  logic                                        master_wready,
  input  logic                                        master_bvalid,
  input  logic_axi4_lite_pkg::response_t              master_bresp,
  output logic                                        master_bready
);

  localparam int unsigned GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [GW-1:0] LAST = GW'(MASTERS - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   grant, grant_d;
  logic [GW-1:0]   pointer, pointer_d;
  logic            aw_done, aw_done_d;
  logic            w_done, w_done_d;
  logic [MASTERS-1:0] req;
  logic [GW-1:0]   pick;
  logic            aw_hs, w_hs;

  assign req = slave_awvalid | slave_wvalid;

  // Round-robin pick: first requester at or after pointer, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = pointer;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      idx = (32'(pointer) + k) % MASTERS;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      grant   <= '0;
      pointer <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      pointer <= pointer_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    pointer_d = pointer;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    slave_awready = '0;
    slave_wready  = '0;
    slave_bvalid  = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      slave_bresp[i] = logic_axi4_lite_pkg::OKAY;
    end

    // Payloads follow grant in every state; only handshakes are gated.
    master_awvalid = 1'b0;
    master_awaddr  = slave_awaddr[grant];
    master_awprot  = slave_awprot[grant];
    master_wvalid  = 1'b0;
    master_wdata   = slave_wdata[grant];
    master_wstrb   = slave_wstrb[grant];
    master_bready  = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          grant_d   = pick;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = XFER;
        end
      end
      XFER: begin
        master_awvalid       = slave_awvalid[grant] & ~aw_done;
        master_wvalid        = slave_wvalid[grant] & ~w_done;
        slave_awready[grant] = master_awready & ~aw_done;
        slave_wready[grant]  = master_wready & ~w_done;
        aw_hs     = master_awvalid & master_awready;
        w_hs      = master_wvalid & master_wready;
        aw_done_d = aw_done | aw_hs;
        w_done_d  = w_done | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end
      end
      RESP: begin
        slave_bvalid[grant] = master_bvalid;
        slave_bresp[grant]  = master_bresp;
        master_bready       = slave_bready[grant];
        if (master_bvalid && master_bready) begin
          pointer_d = (grant == LAST) ? '0 : grant + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_logic_axi4_lite_write_arbiter.sv
// Bench for logic_axi4_lite_write_arbiter: directed scenarios plus randomized
// traffic against a transaction-owner reference model (MASTERS=2), and a
// MASTERS=3 instance for the wrap-around arbitration case.
module tb_logic_axi4_lite_write_arbiter;
  import logic_axi4_lite_pkg::*;

  localparam int M  = 2;
  localparam int DB = 4;
  localparam int AW = 10;

  logic aclk = 1'b0;
  logic areset_n;
  always #5 aclk = ~aclk;

  // MASTERS=2 instance signals
  logic [M-1:0]                s_awvalid, s_awready, s_wvalid, s_wready;
  logic [M-1:0]                s_bready, s_bvalid;
  logic [M-1:0][AW-1:0]        s_awaddr;
  access_t [M-1:0]             s_awprot;
  logic [M-1:0][DB-1:0][7:0]   s_wdata;
  logic [M-1:0][DB-1:0]        s_wstrb;
  response_t [M-1:0]           s_bresp;
  logic                        master_awvalid, m_awready, master_wvalid, m_wready;
  logic                        m_bvalid, master_bready;
  logic [AW-1:0]               master_awaddr;
  access_t                     master_awprot;
  logic [DB*8-1:0]             master_wdata;
  logic [DB-1:0]               master_wstrb;
  response_t                   m_bresp;

  // MASTERS=3 instance signals
  logic [2:0]                  t_awvalid, t_awready, t_wvalid, t_wready, t_bready, t_bvalid;
  logic [2:0][AW-1:0]          t_awaddr;
  access_t [2:0]               t_awprot;
  logic [2:0][DB-1:0][7:0]     t_wdata;
  logic [2:0][DB-1:0]          t_wstrb;
  response_t [2:0]             t_bresp;
  logic                        t_mawvalid, t_mawready, t_mwvalid, t_mwready, t_mbvalid, t_mbready;
  logic [AW-1:0]               t_mawaddr;
  access_t                     t_mawprot;
  logic [DB*8-1:0]             t_mwdata;
  logic [DB-1:0]               t_mwstrb;
  response_t                   t_mbresp;

  logic_axi4_lite_write_arbiter #(.MASTERS(M), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) u_dut (
    .aclk(aclk), .areset_n(areset_n),
    .slave_awvalid(s_awvalid), .slave_awaddr(s_awaddr), .slave_awprot(s_awprot),
    .slave_awready(s_awready), .slave_wvalid(s_wvalid), .slave_wdata(s_wdata),
    .slave_wstrb(s_wstrb), .slave_wready(s_wready), .slave_bready(s_bready),
    .slave_bvalid(s_bvalid), .slave_bresp(s_bresp),
    .master_awvalid(master_awvalid), .master_awaddr(master_awaddr),
    .master_awprot(master_awprot), .master_awready(m_awready),
    .master_wvalid(master_wvalid), .master_wdata(master_wdata),
    .master_wstrb(master_wstrb), .master_wready(m_wready),
    .master_bvalid(m_bvalid), .master_bresp(m_bresp), .master_bready(master_bready)
  );

  logic_axi4_lite_write_arbiter #(.MASTERS(3), .DATA_BYTES(DB), .ADDRESS_WIDTH(AW)) u_dut3 (
    .aclk(aclk), .areset_n(areset_n),
    .slave_awvalid(t_awvalid), .slave_awaddr(t_awaddr), .slave_awprot(t_awprot),
    .slave_awready(t_awready), .slave_wvalid(t_wvalid), .slave_wdata(t_wdata),
    .slave_wstrb(t_wstrb), .slave_wready(t_wready), .slave_bready(t_bready),
    .slave_bvalid(t_bvalid), .slave_bresp(t_bresp),
    .master_awvalid(t_mawvalid), .master_awaddr(t_mawaddr),
    .master_awprot(t_mawprot), .master_awready(t_mawready),
    .master_wvalid(t_mwvalid), .master_wdata(t_mwdata),
    .master_wstrb(t_mwstrb), .master_wready(t_mwready),
    .master_bvalid(t_mbvalid), .master_bresp(t_mbresp), .master_bready(t_mbready)
  );

  int n_vec;
  int n_bad;

  // Reference model: owner of the current write (-1 when none), the next
  // requester to favour, the last owner (selects payloads), and whether the
  // owner's address and data have already been accepted downstream.
  int owner;
  int rr;
  int last;
  bit got_aw;
  bit got_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    rr     = 0;
    last   = 0;
    got_aw = 1'b0;
    got_w  = 1'b0;
  endtask

  task automatic model_update();
    bit found;
    int j;
    found = 1'b0;
    if (owner < 0) begin
      for (int k = 0; k < M; k++) begin
        j = (rr + k) % M;
        if (!found && (s_awvalid[j] || s_wvalid[j])) begin
          found  = 1'b1;
          owner  = j;
          last   = j;
          got_aw = 1'b0;
          got_w  = 1'b0;
        end
      end
    end else if (!(got_aw && got_w)) begin
      if (s_awvalid[owner] && m_awready) got_aw = 1'b1;
      if (s_wvalid[owner] && m_wready)   got_w  = 1'b1;
    end else if (m_bvalid && s_bready[owner]) begin
      rr    = (owner + 1) % M;
      owner = -1;
    end
  endtask

  task automatic compare_all();
    bit in_resp;
    bit in_xfer;
    int o;
    logic [M-1:0] e_awr, e_wr, e_bv;
    response_t [M-1:0] e_br;
    in_resp = (owner >= 0) && got_aw && got_w;
    in_xfer = (owner >= 0) && !in_resp;
    o = (owner >= 0) ? owner : 0;
    e_awr = '0;
    e_wr  = '0;
    e_bv  = '0;
    for (int i = 0; i < M; i++) e_br[i] = OKAY;
    if (in_xfer) begin
      e_awr[o] = m_awready && !got_aw;
      e_wr[o]  = m_wready && !got_w;
    end
    if (in_resp) begin
      e_bv[o] = m_bvalid;
      e_br[o] = m_bresp;
    end
    check("m_awvalid", 64'(master_awvalid), 64'(in_xfer && s_awvalid[o] && !got_aw));
    check("m_wvalid",  64'(master_wvalid),  64'(in_xfer && s_wvalid[o] && !got_w));
    check("m_bready",  64'(master_bready),  64'(in_resp && s_bready[o]));
    check("m_awaddr",  64'(master_awaddr),  64'(s_awaddr[last]));
    check("m_awprot",  64'(master_awprot),  64'(s_awprot[last]));
    check("m_wdata",   64'(master_wdata),   64'(s_wdata[last]));
    check("m_wstrb",   64'(master_wstrb),   64'(s_wstrb[last]));
    check("s_awready", 64'(s_awready), 64'(e_awr));
    check("s_wready",  64'(s_wready),  64'(e_wr));
    check("s_bvalid",  64'(s_bvalid),  64'(e_bv));
    check("s_bresp",   64'(s_bresp),   64'(e_br));
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge aclk);
    if (areset_n) model_update();
    @(negedge aclk);
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = OKAY;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    areset_n = 1'b0;
    clear_inputs();
    s_awaddr[0] = 10'h3C3; s_awaddr[1] = 10'h155;
    s_awprot[0] = 3'd5;    s_awprot[1] = 3'd2;
    s_wdata[0]  = 32'h1234_5678; s_wdata[1] = 32'h0BAD_F00D;
    s_wstrb[0]  = 4'h3;    s_wstrb[1] = 4'hC;
    t_awvalid = '0; t_wvalid = '0; t_bready = '0; t_awaddr = '0; t_awprot = '0;
    t_wdata = '0; t_wstrb = '0; t_mawready = 1'b0; t_mwready = 1'b0;
    t_mbvalid = 1'b0; t_mbresp = OKAY;
    model_reset();

    // Reset state
    @(negedge aclk);
    settle();
    check("rst_awvalid", 64'(master_awvalid), 64'h0);
    check("rst_awaddr",  64'(master_awaddr),  64'h3C3);
    check("rst_wdata",   64'(master_wdata),   64'h1234_5678);
    check("rst_t3_ready", 64'(t_awready | t_wready | t_bvalid), 64'h0);
    advance();
    areset_n = 1'b1;

    // Single write from requester 1
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    s_awaddr[1] = 10'h010; s_wdata[1] = 32'hA5A5_A5A5; s_wstrb[1] = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    settle();
    check("t1_idle_awvalid", 64'(master_awvalid), 64'h0);
    advance();
    settle();
    check("t1_awvalid", 64'(master_awvalid), 64'h1);
    check("t1_awaddr",  64'(master_awaddr),  64'h10);
    check("t1_wdata",   64'(master_wdata),   64'hA5A5_A5A5);
    check("t1_awready", 64'(s_awready),      64'h2);
    advance();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; m_bresp = OKAY; s_bready = 2'b11;
    settle();
    check("t1_bvalid", 64'(s_bvalid), 64'h2);
    check("t1_bresp",  64'(s_bresp),  64'h0);
    advance();
    m_bvalid = 1'b0;

    // Both requesters continuously: grants alternate starting from 0
    s_awvalid = 2'b11; s_wvalid = 2'b11; m_bvalid = 1'b1; s_bready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      settle();
      check("t2_idle_ready", 64'(s_awready | s_wready), 64'h0);
      advance();
      settle();
      check("t2_grant_aw", 64'(s_awready), (t % 2 == 1) ? 64'h2 : 64'h1);
      check("t2_grant_w",  64'(s_wready),  (t % 2 == 1) ? 64'h2 : 64'h1);
      advance();
      settle();
      check("t2_bvalid", 64'(s_bvalid), (t % 2 == 1) ? 64'h2 : 64'h1);
      advance();
    end
    clear_inputs();

    // W three cycles ahead of AW on requester 0
    s_wvalid = 2'b01; m_awready = 1'b1; m_wready = 1'b1;
    settle();
    advance();
    settle();
    check("t3_w_alone", 64'(s_wready), 64'h1);
    check("t3_no_aw",   64'(master_awvalid), 64'h0);
    advance();
    for (int c = 0; c < 2; c++) begin
      s_wdata[0] = $urandom;
      settle();
      check("t3_w2_blocked", 64'(master_wvalid), 64'h0);
      check("t3_wready_off", 64'(s_wready), 64'h0);
      advance();
    end
    s_awvalid = 2'b01; s_wvalid = 2'b00;
    settle();
    check("t3_aw", 64'(master_awvalid), 64'h1);
    check("t3_awready", 64'(s_awready), 64'h1);
    advance();
    s_awvalid = '0; m_bvalid = 1'b1; s_bready = 2'b01;
    settle();
    check("t3_resp_bvalid", 64'(s_bvalid), 64'h1);
    advance();
    clear_inputs();

    // SLVERR held while requester 1 withholds bready
    s_awvalid = 2'b10; s_wvalid = 2'b10; m_awready = 1'b1; m_wready = 1'b1;
    settle(); advance();
    settle(); advance();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; m_bresp = SLVERR; s_bready = 2'b00;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t4_hold_bvalid", 64'(s_bvalid), 64'h2);
      check("t4_hold_bready", 64'(master_bready), 64'h0);
      advance();
    end
    s_bready = 2'b10;
    settle();
    check("t4_bresp",  64'(s_bresp[1]), 64'(SLVERR));
    check("t4_bready", 64'(master_bready), 64'h1);
    advance();
    m_bvalid = 1'b0;
    settle();
    check("t4_idle_bvalid", 64'(s_bvalid), 64'h0);
    advance();
    clear_inputs();

    // Asynchronous reset after the AW handshake, W still outstanding
    s_awvalid = 2'b01; s_wvalid = 2'b01; m_awready = 1'b1; m_wready = 1'b0;
    settle(); advance();
    settle(); advance();
    settle();
    check("t5_pre_wvalid", 64'(master_wvalid), 64'h1);
    #2;
    areset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("t5_rst_wvalid",  64'(master_wvalid), 64'h0);
    check("t5_rst_readies", 64'(s_awready | s_wready), 64'h0);
    advance();
    areset_n = 1'b1;
    s_awvalid = 2'b11; s_wvalid = 2'b11; m_awready = 1'b1; m_wready = 1'b1;
    settle(); advance();
    settle();
    check("t5_after_grant", 64'(s_awready), 64'h1);
    advance();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; s_bready = 2'b11;
    settle();
    check("t5_after_bvalid", 64'(s_bvalid), 64'h1);
    advance();
    clear_inputs();

    // MASTERS=3: after serving requester 1 the scan starts at 2 and wraps to 0
    t_awvalid = 3'b010; t_wvalid = 3'b010; t_mawready = 1'b1; t_mwready = 1'b1;
    t_mbvalid = 1'b1; t_bready = 3'b111;
    settle(); advance();
    settle();
    check("t6_first_grant", 64'(t_awready), 64'h2);
    advance();
    settle(); advance();
    t_awvalid = 3'b011; t_wvalid = 3'b011;
    settle(); advance();
    settle();
    check("t6_wrap_grant", 64'(t_awready), 64'h1);
    advance();
    settle();
    check("t6_wrap_bvalid", 64'(t_bvalid), 64'h1);
    advance();
    t_awvalid = '0; t_wvalid = '0; t_mbvalid = 1'b0;

    // Randomized traffic, including stray bvalid and occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      s_awvalid = 2'($urandom);
      s_wvalid  = 2'($urandom);
      s_bready  = 2'($urandom);
      for (int i = 0; i < M; i++) begin
        s_awaddr[i] = 10'($urandom);
        s_awprot[i] = 3'($urandom);
        s_wdata[i]  = $urandom;
        s_wstrb[i]  = 4'($urandom);
      end
      m_awready = 1'($urandom);
      m_wready  = 1'($urandom);
      m_bvalid  = 1'($urandom);
      m_bresp   = response_t'($urandom_range(0, 3));
      settle();
      if ($urandom_range(0, 79) == 0) begin
        #2;
        areset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        advance();
        areset_n = 1'b1;
      end else begin
        advance();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
